// File: rtl/i2c_sda_ctrl.sv
// SDA data stage of the I2C master: drives START/address/data/ACK/STOP onto SDA
// and samples slave ACK and read data at mid-SCL-high.
module i2c_sda_ctrl #(
  parameter int unsigned T_LOW    = 6,
  parameter int unsigned T_HIGH   = 4,
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned CHG_PT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state_master,
  input  logic [6:0] count_ctrl,
  input  logic [3:0] count,
  input  logic       count_inc,
  input  logic       load_addr,
  input  logic [6:0] slave_addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  input  logic       send_nack,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       ack_ok,
  output logic       ack_valid
);

  localparam int unsigned SAMPLE_PT = T_LOW + T_HIGH / 2;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_READY        = 4'd1,
    ST_SEND_ADDR    = 4'd2,
    ST_CHK_ACK_ADDR = 4'd3,
    ST_WRITE        = 4'd4,
    ST_CHK_ACK_DATA = 4'd5,
    ST_READ         = 4'd6,
    ST_SEND_ACK     = 4'd7,
    ST_STOP         = 4'd8
  } state_t;

  logic [3:0] prev_state;
  logic [7:0] tx_sr, rx_sr;
  logic [7:0] tx_nxt, rx_nxt, tx_cur, rx_cur, rd_data_nxt;
  logic       sda_out_nxt, sda_oe_nxt, rd_valid_nxt, ack_ok_nxt, ack_valid_nxt;
  logic       entry, at_chg, at_sample, last_bit;

  assign entry     = (state_master != prev_state);
  assign at_chg    = (count_ctrl == 7'(CHG_PT));
  assign at_sample = (count_ctrl == 7'(SAMPLE_PT));
  assign last_bit  = (count == 4'(DATA_LEN - 1));

  // Next-value logic; the state seen this cycle (including one just entered) wins.
  always_comb begin
    tx_nxt        = tx_sr;
    rx_nxt        = rx_sr;
    rd_data_nxt   = rd_data;
    sda_out_nxt   = sda_out;
    sda_oe_nxt    = sda_oe;
    rd_valid_nxt  = 1'b0;
    ack_ok_nxt    = ack_ok;
    ack_valid_nxt = 1'b0;
    tx_cur        = (state_master == ST_WRITE && entry) ? wr_data : tx_sr;
    rx_cur        = (state_master == ST_READ && entry) ? 8'h00 : rx_sr;

    case (state_master)
      ST_IDLE: begin
        sda_oe_nxt  = 1'b0;
        sda_out_nxt = 1'b1;
        if (load_addr) tx_nxt = {slave_addr, rw};
      end
      ST_READY: begin
        sda_oe_nxt  = 1'b1;
        sda_out_nxt = 1'b0;
      end
      ST_SEND_ADDR, ST_WRITE: begin
        sda_oe_nxt = 1'b1;
        tx_nxt     = tx_cur;
        if (at_chg) sda_out_nxt = tx_cur[7];
        if (count_inc) tx_nxt = {tx_cur[6:0], 1'b0};
      end
      ST_CHK_ACK_ADDR, ST_CHK_ACK_DATA: begin
        if (at_chg) sda_oe_nxt = 1'b0;
        if (at_sample) begin
          ack_ok_nxt    = ~sda_in;
          ack_valid_nxt = 1'b1;
        end
      end
      ST_READ: begin
        rx_nxt = rx_cur;
        if (at_chg) sda_oe_nxt = 1'b0;
        if (at_sample) begin
          rx_nxt = {rx_cur[6:0], sda_in};
          if (last_bit) begin
            rd_data_nxt  = {rx_cur[6:0], sda_in};
            rd_valid_nxt = 1'b1;
          end
        end
      end
      ST_SEND_ACK: begin
        if (at_chg) begin
          sda_oe_nxt  = 1'b1;
          sda_out_nxt = send_nack;
        end
      end
      ST_STOP: begin
        if (at_chg) begin
          sda_oe_nxt  = 1'b1;
          sda_out_nxt = 1'b0;
        end
        if (at_sample) sda_out_nxt = 1'b1;
      end
      default: begin
        sda_oe_nxt  = 1'b0;
        sda_out_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state <= ST_IDLE;
      tx_sr      <= 8'h00;
      rx_sr      <= 8'h00;
      sda_out    <= 1'b1;
      sda_oe     <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      ack_ok     <= 1'b0;
      ack_valid  <= 1'b0;
    end else begin
      prev_state <= state_master;
      tx_sr      <= tx_nxt;
      rx_sr      <= rx_nxt;
      sda_out    <= sda_out_nxt;
      sda_oe     <= sda_oe_nxt;
      rd_data    <= rd_data_nxt;
      rd_valid   <= rd_valid_nxt;
      ack_ok     <= ack_ok_nxt;
      ack_valid  <= ack_valid_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_sda_ctrl.sv
// Bench for i2c_sda_ctrl: models the master FSM / SCL counter and scoreboards
// expected SDA bits, ACK results and read bytes.
module tb_i2c_sda_ctrl;

  localparam int unsigned T_BIT = 10;
  localparam logic [3:0] S_IDLE = 4'd0, S_READY = 4'd1, S_ADDR = 4'd2, S_CKA = 4'd3,
                         S_WR = 4'd4, S_CKD = 4'd5, S_RD = 4'd6, S_SACK = 4'd7,
                         S_STOP = 4'd8, S_BAD = 4'hC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state_master = 4'd0;
  logic [6:0] count_ctrl = 7'd0;
  logic [3:0] count = 4'd0;
  logic       count_inc = 1'b0;
  logic       load_addr = 1'b0;
  logic [6:0] slave_addr = 7'd0;
  logic       rw = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       send_nack = 1'b0;
  logic       sda_in = 1'b1;
  logic       sda_out, sda_oe, rd_valid, ack_ok, ack_valid;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic       sda_q[$];
  logic       ack_q[$];
  logic [7:0] rd_q[$];

  i2c_sda_ctrl dut (
    .clk(clk), .rst(rst), .state_master(state_master), .count_ctrl(count_ctrl),
    .count(count), .count_inc(count_inc), .load_addr(load_addr),
    .slave_addr(slave_addr), .rw(rw), .wr_data(wr_data), .send_nack(send_nack),
    .sda_in(sda_in), .sda_out(sda_out), .sda_oe(sda_oe), .rd_data(rd_data),
    .rd_valid(rd_valid), .ack_ok(ack_ok), .ack_valid(ack_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Observes outputs produced by the previous cycle's inputs (cycle c-1 of this bit).
  task automatic monitor(input logic [3:0] st, input logic [3:0] idx, input int c);
    logic e;
    logic [7:0] b;
    if (c > 0) begin
      case (st)
        S_ADDR, S_WR: begin
          check("tx_oe", sda_oe, 1);
          if (c == 8) begin
            if (sda_q.size() > 0) begin
              e = sda_q.pop_front();
              check("sda_bit", sda_out, e);
            end else check("sda_q_size", 8'(sda_q.size()), 1);
          end
        end
        S_READY: if (c == 5) begin
          check("start_oe", sda_oe, 1);
          check("start_sda", sda_out, 0);
        end
        S_CKA, S_CKD, S_RD: if (c == 8) check("release_oe", sda_oe, 0);
        S_SACK: if (c == 8) begin
          check("sack_oe", sda_oe, 1);
          check("sack_sda", sda_out, send_nack);
        end
        S_STOP: begin
          if (c == 2) begin
            check("stop_oe", sda_oe, 1);
            check("stop_low", sda_out, 0);
          end
          if (c == 9) check("stop_high", sda_out, 1);
        end
        default: begin
          check("idle_oe", sda_oe, 0);
          check("idle_sda", sda_out, 1);
        end
      endcase
    end
    check("ack_valid", ack_valid, 8'((c == 9) && (st == S_CKA || st == S_CKD)));
    if (ack_valid) begin
      if (ack_q.size() > 0) begin
        e = ack_q.pop_front();
        check("ack_ok", ack_ok, e);
      end else check("ack_q_size", 8'(ack_q.size()), 1);
    end
    check("rd_valid", rd_valid, 8'((c == 9) && st == S_RD && idx == 4'd7));
    if (rd_valid) begin
      if (rd_q.size() > 0) begin
        b = rd_q.pop_front();
        check("rd_data", rd_data, b);
      end else check("rd_q_size", 8'(rd_q.size()), 1);
    end
  endtask

  task automatic run_bit(input logic [3:0] st, input logic [3:0] idx, input logic sin,
                         input logic exp_bit);
    if (st == S_ADDR || st == S_WR) sda_q.push_back(exp_bit);
    if (st == S_CKA || st == S_CKD) ack_q.push_back(~sin);
    for (int c = 0; c < int'(T_BIT); c++) begin
      @(negedge clk);
      monitor(st, idx, c);
      state_master = st;
      count_ctrl   = 7'(c);
      count        = idx;
      count_inc    = (c == int'(T_BIT) - 1);
      sda_in       = sin;
      load_addr    = 1'b0;
    end
  endtask

  // Free-running cycles in a state with no bit framing; count_inc toggles.
  task automatic run_cycles(input logic [3:0] st, input int n, input int ld_at);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      monitor(st, 4'd0, (c == 9) ? 10 : c);
      state_master = st;
      count_ctrl   = 7'(c % int'(T_BIT));
      count_inc    = c[0];
      load_addr    = (c == ld_at);
    end
    load_addr = 1'b0;
  endtask

  task automatic send_byte(input logic [3:0] st, input logic [7:0] b);
    for (int i = 0; i < 8; i++) run_bit(st, 4'(i), 1'b1, b[7-i]);
  endtask

  task automatic read_byte(input logic [7:0] b);
    rd_q.push_back(b);
    for (int i = 0; i < 8; i++) run_bit(S_RD, 4'(i), b[7-i], 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_oe", sda_oe, 0);
    check("rst_sda", sda_out, 1);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ack_valid", ack_valid, 0);
    check("rst_ack_ok", ack_ok, 0);
    rst = 1'b0;

    // Address 0x5A + read -> 1,0,1,1,0,1,0,1
    slave_addr = 7'h5A;
    rw         = 1'b1;
    run_cycles(S_IDLE, 4, 1);
    run_bit(S_READY, 4'd0, 1'b1, 1'b0);
    send_byte(S_ADDR, 8'hB5);
    run_bit(S_CKA, 4'd0, 1'b0, 1'b0);

    // Write 0xC3 acked, then again not acked
    wr_data = 8'hC3;
    send_byte(S_WR, 8'hC3);
    run_bit(S_CKD, 4'd0, 1'b0, 1'b0);
    send_byte(S_WR, 8'hC3);
    run_bit(S_CKD, 4'd0, 1'b1, 1'b0);

    // Read 0xA7, NACK it, STOP
    read_byte(8'hA7);
    send_nack = 1'b1;
    run_bit(S_SACK, 4'd0, 1'b1, 1'b0);
    run_bit(S_STOP, 4'd0, 1'b1, 1'b0);
    run_cycles(S_IDLE, 5, -1);

    // Illegal state must not disturb a loaded address (0x33 write -> 0x66)
    slave_addr = 7'h33;
    rw         = 1'b0;
    run_cycles(S_IDLE, 3, 1);
    run_cycles(S_BAD, 20, -1);
    run_bit(S_READY, 4'd0, 1'b1, 1'b0);
    send_byte(S_ADDR, 8'h66);
    run_bit(S_CKA, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write byte
    wr_data = 8'h96;
    run_bit(S_WR, 4'd0, 1'b1, 1'b1);
    run_bit(S_WR, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("pre_rst_oe", sda_oe, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_oe", sda_oe, 0);
    check("async_rst_sda", sda_out, 1);
    check("async_rst_rd_data", rd_data, 8'h00);
    check("async_rst_rd_valid", rd_valid, 0);
    check("async_rst_ack_valid", ack_valid, 0);
    @(negedge clk);
    state_master = S_IDLE;
    rst = 1'b0;
    run_cycles(S_IDLE, 3, -1);

    check("sda_q_left", 8'(sda_q.size()), 0);
    check("ack_q_left", 8'(ack_q.size()), 0);
    check("rd_q_left", 8'(rd_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
